dmem_rr_arbiter: RTL and testbench

- Round-robin arbiter between the N multicycle ARM cores and one single-port synchronous data RAM.
- Replaces the current OR-ed shared write enable, under which simultaneous stores corrupt memory.
- Sits downstream of the cores' MemWrite/ALUResult/WriteData/ReadData interface and upstream of the dmem.
- Serialises accesses: one granted transaction per 2 cycles under continuous load. Grant index is exported for ILA debug.

---
 rtl/dmem_rr_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter that serialises the cores' data-memory accesses onto a
// single-port synchronous RAM. Each transaction takes an accept cycle, one
// RAM access cycle and one response cycle; the response cycle also arbitrates,
// so under continuous load a new transaction is accepted every second cycle.
module dmem_rr_arbiter #(
    parameter int N  = 8,
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_we,
    input  logic [N*32-1:0]      req_addr,
    input  logic [N*DW-1:0]      req_wdata,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IW = $clog2(N);
    // N widened by one bit so the wrap-around compare/subtract cannot overflow
    localparam logic [IW:0] NWIDE = (IW+1)'(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    stateT           state;
    stateT           stateNext;

    // Control: most recently served core, owner of the current transaction
    logic [IW-1:0]   lastIdx;
    logic [IW-1:0]   grantId;

    // Transaction latched at accept time
    logic            weReg;
    logic [AW-1:0]   addrReg;
    logic [DW-1:0]   wdataReg;

    // Arbitration network
    logic [IW-1:0]   pickLast;
    logic [IW:0]     rotBase;
    logic [N-1:0]    reqRot;
    logic [IW:0]     rotOffs;
    logic [IW:0]     winSum;
    logic            found;
    logic [IW-1:0]   winIdx;
    logic            arbOpen;
    logic            accept;

    // Request fields of the current winner
    logic            pickWe;
    logic [AW-1:0]   pickAddr;
    logic [DW-1:0]   pickWdata;

    // Byte-lane and high address bits are deliberately ignored
    logic            unusedAddrBits;
    assign unusedAddrBits = ^req_addr;

    // In the response cycle the just-served core must be treated as "last"
    // even though lastIdx only catches up at the end of that cycle.
    assign pickLast = (state == RESP) ? grantId : lastIdx;

    // Arbitration is only open outside ACCESS and never while reset is held.
    assign arbOpen  = (state != ACCESS) && !reset;
    assign accept   = arbOpen && found;

    // Rotate the request vector so the core after pickLast sits at bit 0,
    // take the first set bit, then map the offset back to a core index.
    always_comb begin
        rotBase = {1'b0, pickLast} + (IW+1)'(1);
        reqRot  = N'({req_valid, req_valid} >> rotBase);
        found   = 1'b0;
        rotOffs = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (reqRot[j]) begin
                found   = 1'b1;
                rotOffs = (IW+1)'(j);
            end
        end
        winSum = rotBase + rotOffs;
        if (winSum >= NWIDE) begin
            winSum = winSum - NWIDE;
        end
        winIdx = winSum[IW-1:0];
    end

    // Select the winning core's write flag, word address and write data.
    always_comb begin
        pickWe    = 1'b0;
        pickAddr  = '0;
        pickWdata = '0;
        for (int i = 0; i < N; i++) begin
            if (winIdx == IW'(i)) begin
                pickWe    = req_we[i];
                pickAddr  = req_addr[32*i+2 +: AW];
                pickWdata = req_wdata[DW*i +: DW];
            end
        end
    end

    // One-hot accept pulse to the winning core.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = N'(1) << winIdx;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and the outputs decoded from registered state.
    always_comb begin
        stateNext = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = '0;
        rsp_rdata = '0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = weReg;
                stateNext = RESP;
            end
            RESP: begin
                rsp_valid = N'(1) << grantId;
                rsp_rdata = weReg ? '0 : mem_rdata;
                stateNext = accept ? ACCESS : IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Round-robin pointer: updated when the served core gets its response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastIdx <= IW'(N - 1);
        end else if (state == RESP) begin
            lastIdx <= grantId;
        end
    end

    // Latch the winner's transaction on accept; write data only for stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grantId  <= '0;
            weReg    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
        end else if (accept) begin
            grantId <= winIdx;
            weReg   <= pickWe;
            addrReg <= pickAddr;
            if (pickWe) begin
                wdataReg <= pickWdata;
            end
        end
    end

    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;
    assign grant_id  = grantId;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: directed scenarios followed by randomized core
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_dmem_rr_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_we;
    logic [N*32-1:0]      req_addr;
    logic [N*DW-1:0]      req_wdata;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
    logic                 busy;
    logic [IW-1:0]        grant_id;

    dmem_rr_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write.
    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Per-core request drivers.
    logic [N-1:0]  vValid;
    logic [N-1:0]  vWe;
    logic [31:0]   vAddr [N];
    logic [DW-1:0] vData [N];

    always_comb begin
        req_valid = vValid;
        req_we    = vWe;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32]  = vAddr[i];
            req_wdata[DW*i +: DW] = vData[i];
        end
    end

    // Transaction-level reference model.
    typedef struct {
        int            core;
        bit            we;
        int            word;
        logic [DW-1:0] data;
        logic [DW-1:0] rdata;
        bit            known;
    } txnT;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            accCycle;
    int            lastServed;
    int            mGrant;
    int            mAccIdx;
    int            mRspIdx;
    txnT           cur;
    logic [DW-1:0] refMem [1<<AW];
    bit            refKnown [1<<AW];
    int            grantLog [$];
    int            agentSt [N];

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        accCycle   = -100;
        lastServed = N - 1;
        mGrant     = 0;
        mAccIdx    = -1;
        mRspIdx    = -1;
    endtask

    // One clock cycle: check at the falling edge, advance the model at the
    // rising edge, return 1 time unit later so the caller can drive inputs.
    task automatic stepCycle();
        int            win;
        logic [N-1:0]  expReady;
        logic [N-1:0]  expRsp;
        bit            inAcc;
        bit            inRsp;
        @(negedge clk);
        inAcc = (cyc == accCycle + 1);
        inRsp = (cyc == accCycle + 2);
        win = -1;
        if (!inAcc) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (lastServed + k) % N;
                if (win < 0 && vValid[idx]) win = idx;
            end
        end
        expReady = '0;
        if (win >= 0) expReady[win] = 1'b1;
        expRsp = '0;
        if (inRsp) expRsp[cur.core] = 1'b1;
        checkEq("req_ready", req_ready, expReady);
        checkEq("mem_en", mem_en, inAcc);
        checkEq("mem_we", mem_we, inAcc && cur.we);
        if (inAcc) begin
            checkEq("mem_addr", mem_addr, cur.word);
            if (cur.we) checkEq("mem_wdata", mem_wdata, cur.data);
        end
        checkEq("rsp_valid", rsp_valid, expRsp);
        if (inRsp && cur.we) checkEq("rsp_rdata_wr", rsp_rdata, 0);
        if (inRsp && !cur.we && cur.known) checkEq("rsp_rdata_rd", rsp_rdata, cur.rdata);
        checkEq("busy", busy, inAcc || inRsp);
        checkEq("grant_id", grant_id, mGrant);
        for (int i = 0; i < N; i++) if (req_ready[i]) grantLog.push_back(i);
        @(posedge clk);
        mAccIdx = -1;
        mRspIdx = inRsp ? cur.core : -1;
        if (inAcc) begin
            if (cur.we) begin
                refMem[cur.word]   = cur.data;
                refKnown[cur.word] = 1'b1;
            end else begin
                cur.rdata = refMem[cur.word];
                cur.known = refKnown[cur.word];
            end
        end
        if (win >= 0) begin
            cur.core   = win;
            cur.we     = vWe[win];
            cur.word   = int'(vAddr[win][AW+1:2]);
            cur.data   = vData[win];
            cur.rdata  = '0;
            cur.known  = 1'b0;
            accCycle   = cyc;
            lastServed = win;
            mGrant     = win;
            mAccIdx    = win;
        end
        cyc++;
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        checkEq("rst_req_ready", req_ready, 0);
        checkEq("rst_rsp_valid", rsp_valid, 0);
        checkEq("rst_rsp_rdata", rsp_rdata, 0);
        checkEq("rst_mem_en", mem_en, 0);
        checkEq("rst_mem_we", mem_we, 0);
        checkEq("rst_mem_addr", mem_addr, 0);
        checkEq("rst_mem_wdata", mem_wdata, 0);
        checkEq("rst_busy", busy, 0);
        checkEq("rst_grant_id", grant_id, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic setReq(input int i, input bit we, input logic [31:0] addr, input logic [DW-1:0] data);
        vValid[i] = 1'b1;
        vWe[i]    = we;
        vAddr[i]  = addr;
        vData[i]  = data;
    endtask

    initial begin
        int exp4 [5];
        logic [31:0] tmp;
        exp4 = '{6, 7, 1, 7, 1};
        vValid = '0;
        vWe    = '0;
        for (int i = 0; i < N; i++) begin
            vAddr[i]   = '0;
            vData[i]   = '0;
            agentSt[i] = 0;
        end
        for (int w = 0; w < (1<<AW); w++) begin
            refMem[w]   = '0;
            refKnown[w] = 1'b0;
        end
        modelReset();
        doReset();

        // Single write from core 3
        setReq(3, 1'b1, 32'h40, 32'hDEAD_BEEF);
        stepCycle();
        vValid[3] = 1'b0;
        repeat (3) stepCycle();
        checkEq("ram_single_write", ram[16], 32'hDEAD_BEEF);

        // Read-back from core 5
        setReq(5, 1'b0, 32'h40, 32'h0);
        stepCycle();
        vValid[5] = 1'b0;
        repeat (3) stepCycle();

        // Full contention straight out of reset
        doReset();
        grantLog.delete();
        for (int i = 0; i < N; i++) setReq(i, 1'b1, 32'(4*i), 32'(i));
        repeat (16) stepCycle();
        vValid = '0;
        repeat (3) stepCycle();
        checkEq("contention_grants", grantLog.size(), N);
        for (int i = 0; i < N; i++) begin
            checkEq("contention_order", (grantLog.size() > i) ? grantLog[i] : -1, i);
            checkEq("contention_ram", ram[i], i);
        end

        // Round-robin wrap: core 6 served, then cores 1 and 7 compete
        grantLog.delete();
        setReq(6, 1'b0, 32'h0, 32'h0);
        stepCycle();
        vValid[6] = 1'b0;
        setReq(1, 1'b1, 32'h104, 32'h1111_0001);
        setReq(7, 1'b1, 32'h108, 32'h7777_0007);
        repeat (8) stepCycle();
        vValid = '0;
        repeat (3) stepCycle();
        checkEq("wrap_grants", grantLog.size(), 5);
        for (int i = 0; i < 5; i++)
            checkEq("wrap_order", (grantLog.size() > i) ? grantLog[i] : -1, exp4[i]);

        // Withdrawn request from core 2 during core 4's access
        grantLog.delete();
        setReq(4, 1'b1, 32'h100, 32'h4444_4444);
        stepCycle();
        vValid[4] = 1'b0;
        setReq(2, 1'b1, 32'h1F0, 32'h2222_2222);
        stepCycle();
        vValid[2] = 1'b0;
        repeat (3) stepCycle();
        checkEq("withdraw_grants", grantLog.size(), 1);
        checkEq("withdraw_winner", (grantLog.size() > 0) ? grantLog[0] : -1, 4);

        // Reset asserted during core 0's access
        setReq(0, 1'b1, 32'h8, 32'h0000_1234);
        stepCycle();
        vValid[0] = 1'b0;
        checkEq("pre_rst_mem_en", mem_en, 1);
        reset = 1'b1;
        #1;
        checkEq("mid_rst_mem_en", mem_en, 0);
        checkEq("mid_rst_mem_we", mem_we, 0);
        checkEq("mid_rst_rsp_valid", rsp_valid, 0);
        checkEq("mid_rst_busy", busy, 0);
        setReq(0, 1'b1, 32'h8, 32'h0000_5678);
        setReq(3, 1'b1, 32'hC, 32'h0000_0333);
        @(negedge clk);
        checkEq("mid_rst_req_ready", req_ready, 0);
        checkEq("mid_rst_rsp_valid2", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        grantLog.delete();
        repeat (4) stepCycle();
        vValid = '0;
        repeat (3) stepCycle();
        checkEq("post_rst_grants", grantLog.size(), 2);
        checkEq("post_rst_first", (grantLog.size() > 0) ? grantLog[0] : -1, 0);
        checkEq("post_rst_second", (grantLog.size() > 1) ? grantLog[1] : -1, 3);

        // Randomized core traffic with holds, withdrawals and stalls
        for (int c = 0; c < 3000; c++) begin
            stepCycle();
            for (int i = 0; i < N; i++) begin
                case (agentSt[i])
                    1: begin
                        if (mAccIdx == i) begin
                            vValid[i]  = 1'b0;
                            agentSt[i] = 2;
                        end else if ($urandom_range(15) == 0) begin
                            vValid[i]  = 1'b0;
                            agentSt[i] = 0;
                        end
                    end
                    2: begin
                        if (mRspIdx == i) agentSt[i] = 0;
                    end
                    default: begin
                        if ($urandom_range(3) == 0) begin
                            tmp = $urandom;
                            agentSt[i] = 1;
                            setReq(i, 1'($urandom_range(1)),
                                   (tmp & 32'hFFFF_FE03) | (32'($urandom_range(15)) << 2),
                                   $urandom);
                        end
                    end
                endcase
            end
        end
        vValid = '0;
        repeat (4) stepCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
